// File: rtl/lstm_mem_pkg.sv
// Shared definitions for the LSTM activation memories.
//   clog2   : address-width helper, never returns less than 1 so that
//             single-entry dimensions still get a legal 1-bit field.
//   RDW_OLD : same-address read-during-write returns the old word.
//   RDW_NEW : same-address read-during-write returns the word being written.
package lstm_mem_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((result < 32) && ((32'd1 << result) < value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lstm_dp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Written as a plain array with a registered read so it maps onto block RAM.
// The read-during-write behaviour on a matching address is fixed by RDW_MODE.
// FILENAME names the initialisation image that accompanies the array.
//   clk_i   : rising-edge clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable; rdata_o only changes on an enabled read
//   raddr_i : read address
//   rdata_o : registered read data
module lstm_dp_ram
    import lstm_mem_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 424,
    parameter int unsigned RDW_MODE = RDW_OLD,
    parameter string       FILENAME = "layer_act.list",
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset: the array and its read register behave as block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            if ((RDW_MODE == RDW_NEW) && we_i && (waddr_i == raddr_i)) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lstm_timestep_memory.sv
// Circular timestep-indexed activation store. The forward pass writes the
// open step and commits it; BPTT reads any retained step by relative age.
//   clk_i      : rising-edge clock
//   rst_ni     : asynchronous active-low reset (pointers and read pipe only)
//   wr_en_i    : write wr_data_i into the open step at wr_idx_i
//   wr_idx_i   : neuron index of the write
//   wr_data_i  : write data
//   commit_i   : close the open step and advance to the next slot
//   rd_en_i    : read request
//   rd_idx_i   : neuron index of the read
//   rd_back_i  : age, 0 = open step, k = k-th most recent committed step
//   rd_data_o  : read data, 0 on an out-of-range request, held between reads
//   rd_valid_o : one-cycle pulse, 1 + OUT_REG cycles after rd_en_i
//   rd_err_o   : request age exceeded the retained count (aligned with valid)
//   count_o    : committed steps retained, 0..TIMESTEP-1
//   full_o     : count_o == TIMESTEP-1
module lstm_timestep_memory
    import lstm_mem_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM      = 53,
    parameter int unsigned TIMESTEP = 8,
    parameter int unsigned OUT_REG  = 0,
    parameter int unsigned RDW_MODE = RDW_OLD,
    parameter string       FILENAME = "layer_act.list",
    localparam int unsigned IW      = clog2(NUM),
    localparam int unsigned TW      = clog2(TIMESTEP + 1),
    localparam int unsigned AW      = clog2(NUM * TIMESTEP)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [IW-1:0]           wr_idx_i,
    input  logic signed [WIDTH-1:0] wr_data_i,
    input  logic                    commit_i,
    input  logic                    rd_en_i,
    input  logic [IW-1:0]           rd_idx_i,
    input  logic [TW-1:0]           rd_back_i,
    output logic signed [WIDTH-1:0] rd_data_o,
    output logic                    rd_valid_o,
    output logic                    rd_err_o,
    output logic [TW-1:0]           count_o,
    output logic                    full_o
);

    localparam logic [TW-1:0] LastSlot = TW'(TIMESTEP - 1);

    logic [TW-1:0]    cur_q, cur_d;
    logic [TW-1:0]    count_q, count_d;
    logic             full;
    logic [TW-1:0]    rd_slot;
    logic             rd_oob;
    logic             ram_re;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] data1;
    logic             v1_q, err1_q, zero_q;

    assign full = (count_q == LastSlot);

    // A commit while full keeps count saturated; the oldest slot simply
    // becomes the new open step.
    always_comb begin
        cur_d   = cur_q;
        count_d = count_q;
        if (commit_i) begin
            cur_d = (cur_q == LastSlot) ? '0 : cur_q + TW'(1);
            if (!full) begin
                count_d = count_q + TW'(1);
            end
        end
    end

    // (cur - back) mod TIMESTEP by compare-and-add. The sum may wrap in TW
    // bits, but the true result is below TIMESTEP so the low bits are exact.
    always_comb begin
        rd_oob = (rd_back_i > count_q);
        if (rd_back_i > cur_q) begin
            rd_slot = cur_q + TW'(TIMESTEP) - rd_back_i;
        end else begin
            rd_slot = cur_q - rd_back_i;
        end
    end

    assign ram_re  = rd_en_i & ~rd_oob;
    assign wr_addr = AW'(cur_q) * AW'(NUM) + AW'(wr_idx_i);
    assign rd_addr = AW'(rd_slot) * AW'(NUM) + AW'(rd_idx_i);

    lstm_dp_ram #(
        .WIDTH    (WIDTH),
        .DEPTH    (NUM * TIMESTEP),
        .RDW_MODE (RDW_MODE),
        .FILENAME (FILENAME)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en_i),
        .waddr_i (wr_addr),
        .wdata_i (wr_data_i),
        .re_i    (ram_re),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // zero_q masks the RAM read register after reset and after an
    // out-of-range read, so rd_data shows 0 and holds it without touching
    // the RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q   <= '0;
            count_q <= '0;
            v1_q    <= 1'b0;
            err1_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            cur_q   <= cur_d;
            count_q <= count_d;
            v1_q    <= rd_en_i;
            err1_q  <= rd_en_i & rd_oob;
            if (rd_en_i) begin
                zero_q <= rd_oob;
            end
        end
    end

    assign data1 = zero_q ? '0 : ram_rdata;

    if (OUT_REG != 0) begin : g_out_reg
        logic             v2_q, err2_q;
        logic [WIDTH-1:0] data2_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2_q    <= 1'b0;
                err2_q  <= 1'b0;
                data2_q <= '0;
            end else begin
                v2_q   <= v1_q;
                err2_q <= err1_q;
                if (v1_q) begin
                    data2_q <= data1;
                end
            end
        end

        assign rd_valid_o = v2_q;
        assign rd_err_o   = err2_q;
        assign rd_data_o  = data2_q;
    end else begin : g_no_out_reg
        assign rd_valid_o = v1_q;
        assign rd_err_o   = err1_q;
        assign rd_data_o  = data1;
    end

    assign count_o = count_q;
    assign full_o  = full;

endmodule

// File: tb/tb_lstm_timestep_memory.sv
// Bench for lstm_timestep_memory with NUM=4, TIMESTEP=3, WIDTH=32.
// Two instances share the stimulus: A (OUT_REG=0, new-data bypass) and
// B (OUT_REG=1, old-data). A reference model pushes expected read results
// with their due cycle; per-instance monitors pop and compare them.
module tb_lstm_timestep_memory;

    localparam int unsigned NUM = 4;
    localparam int unsigned TS  = 3;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               wr_en, commit, rd_en;
    logic [1:0]         wr_idx, rd_idx, rd_back;
    logic signed [31:0] wr_data;

    logic signed [31:0] rd_data_a, rd_data_b;
    logic               rd_valid_a, rd_valid_b, rd_err_a, rd_err_b, full_a, full_b;
    logic [1:0]         count_a, count_b;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] m_mem [NUM*TS];
    int          m_cur;
    int          m_cnt;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_a, last_b;

    lstm_timestep_memory #(
        .WIDTH (32), .NUM (NUM), .TIMESTEP (TS), .OUT_REG (0), .RDW_MODE (1), .FILENAME ("")
    ) u_dut_a (
        .clk_i (clk), .rst_ni (rst_n), .wr_en_i (wr_en), .wr_idx_i (wr_idx),
        .wr_data_i (wr_data), .commit_i (commit), .rd_en_i (rd_en), .rd_idx_i (rd_idx),
        .rd_back_i (rd_back), .rd_data_o (rd_data_a), .rd_valid_o (rd_valid_a),
        .rd_err_o (rd_err_a), .count_o (count_a), .full_o (full_a)
    );

    lstm_timestep_memory #(
        .WIDTH (32), .NUM (NUM), .TIMESTEP (TS), .OUT_REG (1), .RDW_MODE (0), .FILENAME ("")
    ) u_dut_b (
        .clk_i (clk), .rst_ni (rst_n), .wr_en_i (wr_en), .wr_idx_i (wr_idx),
        .wr_data_i (wr_data), .commit_i (commit), .rd_en_i (rd_en), .rd_idx_i (rd_idx),
        .rd_back_i (rd_back), .rd_data_o (rd_data_b), .rd_valid_o (rd_valid_b),
        .rd_err_o (rd_err_b), .count_o (count_b), .full_o (full_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitors: a result is required exactly at its due cycle;
    // otherwise valid must be low and rd_data must hold its last value.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            checks++;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                if (rd_valid_a !== 1'b1 || rd_err_a !== e.err || rd_data_a !== e.data) begin
                    failures++;
                    $display("FAIL sb_a cyc=%0d: valid=%b err=%b data=%h, want 1 %b %h",
                             cyc, rd_valid_a, rd_err_a, rd_data_a, e.err, e.data);
                end
                last_a = e.data;
            end else if (rd_valid_a !== 1'b0 || rd_err_a !== 1'b0 || rd_data_a !== last_a) begin
                failures++;
                $display("FAIL idle_a cyc=%0d: valid=%b err=%b data=%h, want 0 0 %h",
                         cyc, rd_valid_a, rd_err_a, rd_data_a, last_a);
            end
            checks++;
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                if (rd_valid_b !== 1'b1 || rd_err_b !== e.err || rd_data_b !== e.data) begin
                    failures++;
                    $display("FAIL sb_b cyc=%0d: valid=%b err=%b data=%h, want 1 %b %h",
                             cyc, rd_valid_b, rd_err_b, rd_data_b, e.err, e.data);
                end
                last_b = e.data;
            end else if (rd_valid_b !== 1'b0 || rd_err_b !== 1'b0 || rd_data_b !== last_b) begin
                failures++;
                $display("FAIL idle_b cyc=%0d: valid=%b err=%b data=%h, want 0 0 %h",
                         cyc, rd_valid_b, rd_err_b, rd_data_b, last_b);
            end
            checks++;
            if (count_a !== 2'(m_cnt) || count_b !== 2'(m_cnt) ||
                full_a !== (m_cnt == TS - 1) || full_b !== (m_cnt == TS - 1)) begin
                failures++;
                $display("FAIL count cyc=%0d: count=%0d/%0d full=%b/%b, want %0d %b", cyc,
                         count_a, count_b, full_a, full_b, m_cnt, (m_cnt == TS - 1));
            end
        end
    end

    // One clock of stimulus; the model resolves reads against pre-edge state.
    task automatic cycle(input logic we, input int widx, input logic [31:0] wd, input logic cm,
                         input logic re, input int ridx, input int back);
        exp_t ea, eb;
        int   slot, raddr, waddr;
        @(negedge clk);
        wr_en = we; wr_idx = 2'(widx); wr_data = wd; commit = cm;
        rd_en = re; rd_idx = 2'(ridx); rd_back = 2'(back);
        waddr = m_cur * NUM + widx;
        if (re) begin
            ea.due = cyc + 1;
            eb.due = cyc + 2;
            ea.err = (back > m_cnt);
            eb.err = ea.err;
            if (ea.err) begin
                ea.data = '0;
                eb.data = '0;
            end else begin
                slot = m_cur - back;
                if (slot < 0) slot += TS;
                raddr   = slot * NUM + ridx;
                eb.data = m_mem[raddr];
                ea.data = (we && waddr == raddr) ? wd : m_mem[raddr];
            end
            qa.push_back(ea);
            qb.push_back(eb);
        end
        @(posedge clk);
        if (we) m_mem[waddr] = wd;
        if (cm) begin
            m_cur = (m_cur + 1) % TS;
            if (m_cnt < TS - 1) m_cnt++;
        end
        #1;
        wr_en = 1'b0; commit = 1'b0; rd_en = 1'b0;
    endtask

    // Issue one cycle with a read and capture each instance at its latency.
    task automatic access(input logic we, input int widx, input logic [31:0] wd, input logic cm,
                          input int ridx, input int back,
                          output logic va, output logic ea, output logic [31:0] da,
                          output logic vb, output logic eb, output logic [31:0] db);
        cycle(we, widx, wd, cm, 1'b1, ridx, back);
        @(negedge clk);
        va = rd_valid_a; ea = rd_err_a; da = rd_data_a;
        @(negedge clk);
        vb = rd_valid_b; eb = rd_err_b; db = rd_data_b;
    endtask

    task automatic write_step(input logic [31:0] base);
        for (int i = 0; i < NUM; i++) cycle(1'b1, i, base + 32'(i), 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 0, '0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        qa.delete(); qb.delete();
        m_cur = 0; m_cnt = 0; last_a = '0; last_b = '0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (rd_valid_a !== 1'b0 || rd_err_a !== 1'b0 || rd_data_a !== 32'sd0 ||
            count_a !== 2'd0 || full_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: valid=%b err=%b data=%h count=%0d full=%b, want all 0",
                     rd_valid_a, rd_err_a, rd_data_a, count_a, full_a);
        end
        checks++;
        if (rd_valid_b !== 1'b0 || rd_err_b !== 1'b0 || rd_data_b !== 32'sd0 ||
            count_b !== 2'd0 || full_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: valid=%b err=%b data=%h count=%0d full=%b, want all 0",
                     rd_valid_b, rd_err_b, rd_data_b, count_b, full_b);
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic va, ea, vb, eb;
        logic [31:0] da, db;
        write_step(32'h10);
        access(1'b0, 0, '0, 1'b0, 2, 1, va, ea, da, vb, eb, db);
        checks++;
        if (va !== 1'b1 || ea !== 1'b0 || da !== 32'h12) begin
            failures++;
            $display("FAIL basic_a: valid=%b err=%b data=%h, want 1 0 00000012", va, ea, da);
        end
        checks++;
        if (vb !== 1'b1 || eb !== 1'b0 || db !== 32'h12) begin
            failures++;
            $display("FAIL basic_b: valid=%b err=%b data=%h, want 1 0 00000012", vb, eb, db);
        end
        checks++;
        if (count_a !== 2'd1 || count_b !== 2'd1) begin
            failures++;
            $display("FAIL basic_count: count=%0d/%0d, want 1", count_a, count_b);
        end
    endtask

    task automatic test_full();
        logic va, ea, vb, eb;
        logic [31:0] da, db;
        apply_reset();
        write_step(32'hA0);
        write_step(32'hB0);
        write_step(32'hC0);
        checks++;
        if (count_a !== 2'd2 || full_a !== 1'b1 || count_b !== 2'd2 || full_b !== 1'b1) begin
            failures++;
            $display("FAIL full_flag: count=%0d/%0d full=%b/%b, want 2 1",
                     count_a, count_b, full_a, full_b);
        end
        access(1'b0, 0, '0, 1'b0, 0, 2, va, ea, da, vb, eb, db);
        checks++;
        if (va !== 1'b1 || ea !== 1'b0 || da !== 32'hB0 || vb !== 1'b1 || eb !== 1'b0 ||
            db !== 32'hB0) begin
            failures++;
            $display("FAIL full_back2: a=%b/%b/%h b=%b/%b/%h, want 1/0/000000b0",
                     va, ea, da, vb, eb, db);
        end
        access(1'b0, 0, '0, 1'b0, 0, 3, va, ea, da, vb, eb, db);
        checks++;
        if (va !== 1'b1 || ea !== 1'b1 || da !== 32'h0 || vb !== 1'b1 || eb !== 1'b1 ||
            db !== 32'h0) begin
            failures++;
            $display("FAIL full_oob: a=%b/%b/%h b=%b/%b/%h, want 1/1/00000000",
                     va, ea, da, vb, eb, db);
        end
    endtask

    // Open slot 0 still holds A0..A3 from the earlier pass.
    task automatic test_rdw();
        logic va, ea, vb, eb;
        logic [31:0] da, db;
        access(1'b1, 1, 32'h55, 1'b0, 1, 0, va, ea, da, vb, eb, db);
        checks++;
        if (va !== 1'b1 || da !== 32'h55) begin
            failures++;
            $display("FAIL rdw_new: valid=%b data=%h, want 1 00000055", va, da);
        end
        checks++;
        if (vb !== 1'b1 || db !== 32'hA1) begin
            failures++;
            $display("FAIL rdw_old: valid=%b data=%h, want 1 000000a1", vb, db);
        end
    endtask

    task automatic test_wr_commit();
        logic va, ea, vb, eb;
        logic [31:0] da, db;
        cycle(1'b1, 0, 32'h77, 1'b1, 1'b0, 0, 0);
        access(1'b0, 0, '0, 1'b0, 0, 1, va, ea, da, vb, eb, db);
        checks++;
        if (da !== 32'h77 || db !== 32'h77 || ea !== 1'b0 || eb !== 1'b0) begin
            failures++;
            $display("FAIL wrc_back1: data=%h/%h err=%b/%b, want 00000077 0", da, db, ea, eb);
        end
        access(1'b0, 0, '0, 1'b0, 0, 0, va, ea, da, vb, eb, db);
        checks++;
        if (da !== 32'hB0 || db !== 32'hB0) begin
            failures++;
            $display("FAIL wrc_back0: data=%h/%h, want 000000b0", da, db);
        end
    endtask

    task automatic test_reset_inflight();
        logic va, ea, vb, eb;
        logic [31:0] da, db;
        cycle(1'b0, 0, '0, 1'b0, 1'b1, 0, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        qa.delete(); qb.delete();
        m_cur = 0; m_cnt = 0; last_a = '0; last_b = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || rd_err_a !== 1'b0 ||
                rd_err_b !== 1'b0 || rd_data_a !== 32'sd0 || rd_data_b !== 32'sd0 ||
                count_a !== 2'd0 || count_b !== 2'd0 || full_a !== 1'b0 || full_b !== 1'b0) begin
                failures++;
                $display("FAIL rst_flight: valid=%b/%b err=%b/%b data=%h/%h count=%0d/%0d, want 0",
                         rd_valid_a, rd_valid_b, rd_err_a, rd_err_b, rd_data_a, rd_data_b,
                         count_a, count_b);
            end
        end
        #2;
        rst_n = 1'b1;
        access(1'b0, 0, '0, 1'b0, 0, 1, va, ea, da, vb, eb, db);
        checks++;
        if (va !== 1'b1 || ea !== 1'b1 || da !== 32'h0 || vb !== 1'b1 || eb !== 1'b1 ||
            db !== 32'h0) begin
            failures++;
            $display("FAIL rst_oob: a=%b/%b/%h b=%b/%b/%h, want 1/1/00000000",
                     va, ea, da, vb, eb, db);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; commit = 1'b0; rd_en = 1'b0;
        wr_idx = '0; rd_idx = '0; rd_back = '0; wr_data = '0;
        m_cur = 0; m_cnt = 0; last_a = '0; last_b = '0;
        test_reset();
        // Give every RAM word a known value before anything reads it.
        for (int s = 0; s < TS; s++) write_step(32'h100 + 32'(s * 16));
        apply_reset();
        test_basic();
        test_full();
        test_rdw();
        test_wr_commit();
        test_reset_inflight();
        test_random();
        repeat (4) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d/%0d, want 0", qa.size(), qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
